// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared state type, line levels and frame helper for the UART TX scheduler
package uart_pkg;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_e;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  // One start bit, the data bits, one stop bit.
  function automatic int frame_bit_times(input int data_w);
    return data_w + 2;
  endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// rtl/uart_tx_frame.sv - serial frame engine: start bit, LSB-first data bits, stop bit
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_byte,
  output logic              o_txd,
  output logic              o_busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  tx_state_e         state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] shift_reg;

  // o_txd is registered one step ahead so it already shows the next bit on each boundary.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      o_txd     <= IDLE_LVL;
      o_busy    <= 1'b0;
      bit_cnt   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_load) begin
            shift_reg <= i_byte;
            bit_cnt   <= '0;
            bit_idx   <= '0;
            o_txd     <= START_BIT;
            o_busy    <= 1'b1;
            state     <= START;
          end
        end
        START: begin
          if (bit_cnt == CNT_LAST) begin
            bit_cnt <= '0;
            o_txd   <= shift_reg[0];
            state   <= DATA;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_cnt == CNT_LAST) begin
            bit_cnt <= '0;
            if (bit_idx == IDX_LAST) begin
              o_txd <= STOP_BIT;
              state <= STOP;
            end else begin
              shift_reg <= shift_reg >> 1;
              o_txd     <= shift_reg[1];
              bit_idx   <= bit_idx + 1'b1;
            end
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_cnt == CNT_LAST) begin
            bit_cnt <= '0;
            o_txd   <= IDLE_LVL;
            o_busy  <= 1'b0;
            state   <= IDLE;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin sharing of one UART transmitter between NUM_REQ byte sources
module uart_tx_sched
  import uart_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [NUM_REQ-1:0]         i_req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  i_req_data,
  output logic [NUM_REQ-1:0]         o_req_ready,
  output logic                       o_txd,
  output logic                       o_busy,
  output logic [$clog2(NUM_REQ)-1:0] o_grant_id
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   win_idx;
  logic [ID_W-1:0]   cand_idx;
  logic              win_found;
  logic              load;
  logic [DATA_W-1:0] load_byte;
  int                cand;

  // Search starts just past the last winner, so it drops to lowest priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = ID_W'(cand);
      if (!win_found && i_req_valid[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    o_req_ready = '0;
    if (!i_rst && !o_busy && win_found) o_req_ready[win_idx] = 1'b1;
  end

  assign load = |o_req_ready;

  always_comb begin
    load_byte = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == ID_W'(k)) load_byte = i_req_data[k*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rr_ptr     <= ID_W'(NUM_REQ - 1);
      o_grant_id <= '0;
    end else if (load) begin
      rr_ptr     <= win_idx;
      o_grant_id <= win_idx;
    end
  end

  uart_tx_frame #(
    .DATA_W       (DATA_W),
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_frame (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (load),
    .i_byte (load_byte),
    .o_txd  (o_txd),
    .o_busy (o_busy)
  );

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - directed scenarios plus randomized traffic against a frame-level reference model
module tb_uart_tx_sched;

  localparam int N     = 4;
  localparam int DW    = 8;
  localparam int CPB   = 4;
  localparam int FRAME = (DW + 2) * CPB;

  logic              clk = 1'b0;
  logic              i_rst = 1'b1;
  logic [N-1:0]      valid = '0;
  logic [N*DW-1:0]   data = '0;
  logic [N-1:0]      o_req_ready;
  logic              o_txd;
  logic              o_busy;
  logic [1:0]        o_grant_id;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  bit chk_en = 1'b0;

  // Reference model: position inside the current frame (-1 when idle), byte on the line, RR pointer.
  int          m_pos = -1;
  logic [7:0]  m_byte = '0;
  int          m_ptr = N - 1;
  int          m_grant = 0;
  logic [N-1:0] m_acc = '0;

  uart_tx_sched #(.NUM_REQ(N), .DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_req_valid (valid),
    .i_req_data  (data),
    .o_req_ready (o_req_ready),
    .o_txd       (o_txd),
    .o_busy      (o_busy),
    .o_grant_id  (o_grant_id)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    int      win;
    int      j;
    int      bit_no;
    logic    e_txd;
    logic [N-1:0] e_ready;
    if (chk_en) begin
      win = -1;
      if (!i_rst && m_pos < 0) begin
        for (int k = 1; k <= N; k++) begin
          j = (m_ptr + k) % N;
          if (win < 0 && valid[j]) win = j;
        end
      end
      e_ready = '0;
      if (win >= 0) e_ready[win] = 1'b1;
      if (m_pos < 0) e_txd = 1'b1;
      else begin
        bit_no = m_pos / CPB;
        if (bit_no == 0) e_txd = 1'b0;
        else if (bit_no <= DW) e_txd = m_byte[bit_no-1];
        else e_txd = 1'b1;
      end
      chk("model_txd", 32'(o_txd), 32'(e_txd));
      chk("model_busy", 32'(o_busy), 32'(m_pos >= 0));
      chk("model_ready", 32'(o_req_ready), 32'(e_ready));
      chk("model_grant_id", 32'(o_grant_id), 32'(m_grant));
      m_acc = '0;
      if (i_rst) begin
        m_pos = -1; m_ptr = N - 1; m_grant = 0;
      end else if (m_pos >= 0) begin
        m_pos++;
        if (m_pos == FRAME) m_pos = -1;
      end else if (win >= 0) begin
        m_pos = 0;
        m_byte = data[win*DW +: DW];
        m_ptr = win;
        m_grant = win;
        m_acc[win] = 1'b1;
      end
    end
  end

  task automatic do_reset();
    i_rst = 1'b1;
    valid = '0;
    repeat (2) @(posedge clk);
    #1 i_rst = 1'b0;
  endtask

  task automatic wait_ready(output int who);
    who = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (o_req_ready != '0) begin
        for (int k = 0; k < N; k++) if (o_req_ready[k]) who = k;
        return;
      end
    end
    n_vec++;
    n_err++;
    $display("FAIL ready_timeout at cycle %0d: got no o_req_ready expected one within 200 cycles", cyc);
  endtask

  initial begin
    int who;
    int last_acc;
    int busy_n;
    logic [9:0] pat;
    int seq2 [5] = '{0, 1, 2, 3, 0};
    int seq3 [4] = '{1, 3, 1, 3};

    @(posedge clk);
    chk_en = 1'b1;
    @(posedge clk);
    #1 i_rst = 1'b0;

    // Scenario 1: single byte 0xA5 from requester 0.
    do_reset();
    data[7:0] = 8'hA5;
    valid = 4'b0001;
    wait_ready(who);
    chk("s1_ready", 32'(o_req_ready), 32'h1);
    @(posedge clk);
    #1 valid = '0;
    pat = 10'b1101001010;
    busy_n = 0;
    for (int i = 0; i < FRAME; i++) begin
      @(negedge clk);
      chk("s1_txd", 32'(o_txd), 32'(pat[i/CPB]));
      if (i == 0) chk("s1_ready_off", 32'(o_req_ready), 32'h0);
      busy_n += int'(o_busy);
    end
    @(negedge clk);
    chk("s1_busy_after", 32'(o_busy), 32'h0);
    chk("s1_txd_after", 32'(o_txd), 32'h1);
    chk("s1_busy_len", 32'(busy_n), 32'd40);

    // Scenario 2: all four valid, round-robin order and accept spacing.
    @(posedge clk);
    #1;
    do_reset();
    data = 32'h44332211;
    valid = 4'b1111;
    last_acc = 0;
    for (int g = 0; g < 5; g++) begin
      wait_ready(who);
      chk("s2_grant", 32'(who), 32'(seq2[g]));
      if (g > 0) chk("s2_gap", 32'(cyc - last_acc), 32'd41);
      last_acc = cyc;
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("s2_grant_id", 32'(o_grant_id), 32'(seq2[g]));
    end
    @(posedge clk);
    #1 valid = '0;

    // Scenario 3: requesters 1 and 3 alternate.
    do_reset();
    data = 32'hC0B0A090;
    valid = 4'b1010;
    for (int g = 0; g < 4; g++) begin
      wait_ready(who);
      chk("s3_grant", 32'(who), 32'(seq3[g]));
      chk("s3_no_even", 32'(o_req_ready & 4'b0101), 32'h0);
    end
    @(posedge clk);
    #1 valid = '0;

    // Scenario 4: data change after accept does not alter the frame.
    do_reset();
    data[23:16] = 8'h5A;
    valid = 4'b0100;
    wait_ready(who);
    chk("s4_grant", 32'(who), 32'd2);
    @(posedge clk);
    #1 valid = '0;
    repeat (2) @(posedge clk);
    #1 data[23:16] = 8'hFF;
    pat = 10'b1010110100;
    for (int b = 0; b < 10; b++) begin
      if (b == 0) @(negedge clk);
      else repeat (CPB) @(negedge clk);
      chk("s4_bit", 32'(o_txd), 32'(pat[b]));
    end
    repeat (CPB) @(posedge clk);
    #1;

    // Scenario 5: reset during data bit 3 truncates the frame and restores priority.
    do_reset();
    data[15:8] = 8'hC3;
    valid = 4'b0010;
    wait_ready(who);
    chk("s5_grant", 32'(who), 32'd1);
    @(posedge clk);
    #1 valid = '0;
    repeat (17) @(posedge clk);
    #1 i_rst = 1'b1;
    data = 32'h0F0E0D0C;
    @(posedge clk);
    #1 i_rst = 1'b0;
    valid = 4'b1111;
    @(negedge clk);
    chk("s5_txd", 32'(o_txd), 32'h1);
    chk("s5_busy", 32'(o_busy), 32'h0);
    chk("s5_first_grant", 32'(o_req_ready), 32'h1);
    @(posedge clk);
    #1 valid = '0;
    repeat (FRAME + 4) @(posedge clk);
    #1;

    // Scenario 6: requester 1 pulses valid mid-frame and is never served.
    do_reset();
    data[7:0] = 8'h3C;
    data[15:8] = 8'h81;
    valid = 4'b0001;
    wait_ready(who);
    chk("s6_grant", 32'(who), 32'd0);
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1 valid = (i >= 10 && i < 13) ? 4'b0010 : 4'b0000;
      @(negedge clk);
      chk("s6_ready1", 32'(o_req_ready[1]), 32'h0);
      if (i > FRAME) begin
        chk("s6_idle_txd", 32'(o_txd), 32'h1);
        chk("s6_idle_busy", 32'(o_busy), 32'h0);
      end
    end

    // Randomized traffic: hold valid/data until accepted, occasional drops and resets.
    @(posedge clk);
    #1;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      i_rst = ($urandom_range(0, 799) == 0);
      for (int k = 0; k < N; k++) begin
        if (valid[k] && !m_acc[k]) begin
          if ($urandom_range(0, 63) == 0) valid[k] = 1'b0;
        end else begin
          valid[k] = ($urandom_range(0, 2) != 0);
          data[k*DW +: DW] = 8'($urandom);
        end
      end
    end
    @(posedge clk);
    #1 i_rst = 1'b0;
    valid = '0;
    repeat (FRAME + 4) @(posedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
